// File: rtl/div3_pkg.sv
// Shared types and helpers for the multiple-of-3 stream path.
// Holds the FSM state encoding and the bit-serial mod-3 step.
package div3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        EMIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int unsigned DIVISOR = 3;

    // One MSB-first step of a running remainder: (2r + b) mod 3.
    function automatic logic [1:0] mod3_step(
        input logic [1:0] r,
        input logic       b
    );
        logic [2:0] t;
        logic [2:0] m;
        t = {r, b};
        m = (t >= 3'(DIVISOR)) ? t - 3'(DIVISOR) : t;
        return m[1:0];
    endfunction

endpackage

// File: rtl/mod3_serial.sv
// Bit-serial mod-3 remainder accumulator, MSB first.
// Clear has priority over enable.
module mod3_serial
    import div3_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [1:0] r_o
);

    logic [1:0] r_q;
    logic [1:0] r_d;

    // Next remainder: clear, fold in one bit, or hold.
    always_comb begin
        r_d = r_q;
        if (clr_i) begin
            r_d = 2'd0;
        end else if (en_i) begin
            r_d = mod3_step(r_q, bit_i);
        end
    end

    // Remainder register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 2'd0;
        end else begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/div3_stream_gen.sv
// Streams every multiple of 3 in [lo, hi] over valid/ready.
// The first multiple is found from a bit-serial lo mod 3.
module div3_stream_gen
    import div3_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] count
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              aligned_q, aligned_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] count_q, count_d;

    logic              r_clr;
    logic              r_en;
    logic              r_bit;
    logic [1:0]        rem;

    logic [1:0]        adj;
    logic [DATA_W:0]   hi_ext;
    logic [DATA_W:0]   first;
    logic [DATA_W:0]   nxt;
    logic              first_out;
    logic              nxt_out;
    logic              xfer;

    mod3_serial u_mod3 (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (r_clr),
        .en_i  (r_en),
        .bit_i (r_bit),
        .r_o   (rem)
    );

    // Range arithmetic: first multiple, next multiple, bound tests.
    always_comb begin
        adj = 2'd0;
        unique case (rem)
            2'd1:    adj = 2'd2;
            2'd2:    adj = 2'd1;
            default: adj = 2'd0;
        endcase
        hi_ext    = {1'b0, hi_q};
        first     = {1'b0, lo_q} + (DATA_W+1)'(adj);
        nxt       = {1'b0, data_q} + (DATA_W+1)'(DIVISOR);
        first_out = first[DATA_W] || (first > hi_ext);
        nxt_out   = nxt[DATA_W] || (nxt > hi_ext);
        xfer      = valid_q && out_ready;
    end

    // Next-state and next-output logic for the stream FSM.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        idx_d     = idx_q;
        aligned_d = aligned_q;
        data_d    = data_q;
        valid_d   = valid_q;
        count_d   = count_q;
        r_clr     = 1'b0;
        r_en      = 1'b0;
        r_bit     = lo_q[idx_q];

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lo_d      = lo;
                    hi_d      = hi;
                    count_d   = '0;
                    r_clr     = 1'b1;
                    idx_d     = IDX_W'(DATA_W-1);
                    aligned_d = 1'b0;
                    state_d   = ALIGN;
                end
            end
            ALIGN: begin
                if (!aligned_q) begin
                    r_en = 1'b1;
                    if (idx_q == '0) begin
                        aligned_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else if (first_out) begin
                    state_d = DONE;
                end else begin
                    data_d  = first[DATA_W-1:0];
                    valid_d = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    count_d = count_q + DATA_W'(1);
                    if (nxt_out) begin
                        valid_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        data_d = nxt[DATA_W-1:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            idx_q     <= '0;
            aligned_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            idx_q     <= idx_d;
            aligned_q <= aligned_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            count_q   <= count_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign count     = count_q;

endmodule

// File: tb/tb_div3_stream_gen.sv
// Randomised bench for div3_stream_gen with a queue-based model.
// Directed ranges pin the model; random ranges stress it.
module tb_div3_stream_gen;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
    logic         done;
    logic [W-1:0] count;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int got_q[$];
    bit prev_stall = 0;
    int prev_data = 0;

    div3_stream_gen #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lo        (lo),
        .hi        (hi),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .count     (count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input bit ok, input string nm,
                         input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endtask

    // Model: every multiple of 3 in [l, h], ascending.
    function automatic int build_exp(input int l, input int h);
        exp_q.delete();
        for (int v = l; v <= h; v++)
            if (v % 3 == 0) exp_q.push_back(v);
        return exp_q.size();
    endfunction

    // Compare process: every transfer against the model queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                check(out_valid && (int'(out_data) == prev_data),
                      "hold", int'(out_data), prev_data);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check(0, "extra_value", int'(out_data), -1);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    check(int'(out_data) == e, "data",
                          int'(out_data), e);
                end
                check(out_data % 3 == 0, "div_by_3",
                      int'(out_data % 3), 0);
                got_q.push_back(int'(out_data));
            end
            prev_stall = out_valid && !out_ready;
            prev_data = int'(out_data);
        end
    end

    // mode 0: ready high; 1: random ready; 2: stall 3 cycles on 3.
    task automatic run(input int l, input int h, input int mode,
                       input bit poke);
        int n_exp;
        int cyc;
        int n;
        int stall;
        n_exp = build_exp(l, h);
        got_q.delete();
        lo = W'(l);
        hi = W'(h);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check(busy == 1, "busy_after_start", int'(busy), 1);
        cyc = 0;
        while (!out_valid && !done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (poke && cyc == 3) begin
                start = 1; lo = 0; hi = 255;
            end
            if (cyc == 4) start = 0;
        end
        check(cyc == W + 1, "first_latency", cyc, W + 1);
        if (n_exp == 0)
            check(done && !out_valid, "empty_done",
                  int'(done), 1);
        else
            check(out_valid == 1, "first_valid",
                  int'(out_valid), 1);
        n = 0;
        stall = 0;
        while (!done && n < 2000) begin
            if (mode == 0) out_ready = 1;
            else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (out_valid && out_data == 3 && stall < 3) begin
                out_ready = 0;
                stall++;
            end else out_ready = 1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 0;
        check(done == 1, "done_seen", int'(done), 1);
        if (mode == 0)
            check(n == n_exp, "throughput", n, n_exp);
        check(int'(count) == n_exp, "count", int'(count), n_exp);
        check(exp_q.size() == 0, "all_sent", exp_q.size(), 0);
        @(posedge clk); #1;
        check(!done && !busy, "idle_after",
              int'({busy, done}), 0);
    endtask

    initial begin
        rst_n = 1;
        start = 0;
        lo = 0;
        hi = 0;
        out_ready = 0;
        #1 rst_n = 0;
        #2;
        check(out_valid == 0, "rst_valid", int'(out_valid), 0);
        check(out_data == 0, "rst_data", int'(out_data), 0);
        check(busy == 0, "rst_busy", int'(busy), 0);
        check(done == 0, "rst_done", int'(done), 0);
        check(count == 0, "rst_count", int'(count), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        void'(build_exp(5, 12));
        check(exp_q.size() == 3 && exp_q[0] == 6 && exp_q[2] == 12,
              "model_5_12", exp_q.size(), 3);

        run(5, 12, 0, 0);
        check(got_q.size() == 3 && got_q[0] == 6 &&
              got_q[1] == 9 && got_q[2] == 12,
              "lit_5_12", got_q.size(), 3);

        run(12, 12, 0, 0);
        check(got_q.size() == 1 && got_q[0] == 12,
              "lit_12_12", got_q.size(), 1);

        run(13, 14, 0, 0);
        check(got_q.size() == 0, "lit_13_14", got_q.size(), 0);

        run(37, 29, 0, 1);
        check(got_q.size() == 0, "lit_37_29", got_q.size(), 0);
        run(5, 12, 0, 0);
        check(got_q.size() == 3 && got_q[0] == 6,
              "after_poke", got_q.size(), 3);

        run(250, 255, 0, 0);
        check(got_q.size() == 2 && got_q[0] == 252 &&
              got_q[1] == 255, "lit_wrap", got_q.size(), 2);

        run(0, 9, 2, 0);
        check(got_q.size() == 4 && got_q[1] == 3 &&
              got_q[3] == 9, "lit_stall", got_q.size(), 4);

        for (int i = 0; i < 25; i++) begin
            int l;
            int h;
            l = $urandom_range(0, 255);
            if (i % 5 == 4) h = $urandom_range(0, 255);
            else h = l + $urandom_range(0, 40);
            if (h > 255) h = 255;
            run(l, h, (i % 3 == 0) ? 0 : 1, 0);
        end

        begin
            int cyc;
            void'(build_exp(0, 255));
            got_q.delete();
            lo = 0;
            hi = 255;
            start = 1;
            out_ready = 1;
            @(posedge clk); #1;
            start = 0;
            cyc = 0;
            while (!out_valid && cyc < 40) begin
                @(posedge clk); #1;
                cyc++;
            end
            repeat (5) @(posedge clk);
            #1;
            check(count == 5, "pre_rst_count", int'(count), 5);
            rst_n = 0;
            #1;
            check(out_valid == 0, "mid_rst_valid",
                  int'(out_valid), 0);
            check(out_data == 0, "mid_rst_data", int'(out_data), 0);
            check(busy == 0 && done == 0, "mid_rst_flags",
                  int'({busy, done}), 0);
            check(count == 0, "mid_rst_count", int'(count), 0);
            out_ready = 0;
            exp_q.delete();
            @(posedge clk); #1;
            rst_n = 1;
            @(posedge clk); #1;
            check(done == 0, "no_done_after_rst", int'(done), 0);
            run(5, 12, 0, 0);
            check(got_q.size() == 3 && got_q[0] == 6 &&
                  got_q[2] == 12, "post_rst", got_q.size(), 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
